// File: rtl/adder_bist.sv
// Built-in self-test controller for a combinational full adder.
// Drives LFSR-generated {a,b,carry_in} vectors, waits a settle interval,
// checks {carry_out,sum} against the arithmetic sum and reports the outcome.
module adder_bist #(
  parameter int unsigned N_VECTORS     = 100,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               dut_a,
  output logic                               dut_b,
  output logic                               dut_carry_in,
  input  logic                               dut_sum,
  input  logic                               dut_carry_out,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               fail,
  output logic [$clog2(N_VECTORS+1)-1:0]     vector_count,
  output logic [2:0]                         error_vector,
  output logic [1:0]                         error_response
);

  localparam int unsigned VCW       = $clog2(N_VECTORS + 1);
  localparam int unsigned SCW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Reject parameter values the controller cannot operate with
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("adder_bist: LFSR_SEED must be nonzero");
  end
  if (N_VECTORS < 1) begin : g_bad_nvec
    $error("adder_bist: N_VECTORS must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("adder_bist: SETTLE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Galois right-shift step of the x^16+x^14+x^13+x^11+1 LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_lfsr, w_lfsr_nxt;
  logic [2:0]       r_stim, w_stim_nxt;
  logic [SCW-1:0]   r_settle, w_settle_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_fail, w_fail_nxt;
  logic [VCW-1:0]   r_vector_count, w_vector_count_nxt;
  logic [2:0]       r_error_vector, w_error_vector_nxt;
  logic [1:0]       r_error_response, w_error_response_nxt;
  logic [1:0]       w_expected;
  logic             w_match;
  logic             w_last;

  assign w_expected = 2'(r_stim[2]) + 2'(r_stim[1]) + 2'(r_stim[0]);
  // X on the response counts as a mismatch in simulation
  assign w_match    = ({dut_carry_out, dut_sum} === w_expected);
  assign w_last     = ((32'(r_vector_count) + 32'd1) == N_VECTORS);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt          = r_state;
    w_lfsr_nxt           = r_lfsr;
    w_stim_nxt           = r_stim;
    w_settle_nxt         = r_settle;
    w_busy_nxt           = r_busy;
    w_done_nxt           = r_done;
    w_pass_nxt           = r_pass;
    w_fail_nxt           = r_fail;
    w_vector_count_nxt   = r_vector_count;
    w_error_vector_nxt   = r_error_vector;
    w_error_response_nxt = r_error_response;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_stim_nxt           = {LFSR_SEED[0], LFSR_SEED[1], LFSR_SEED[2]};
          w_lfsr_nxt           = lfsr_next(LFSR_SEED);
          w_vector_count_nxt   = '0;
          w_done_nxt           = 1'b0;
          w_pass_nxt           = 1'b0;
          w_fail_nxt           = 1'b0;
          w_error_vector_nxt   = '0;
          w_error_response_nxt = '0;
          w_busy_nxt           = 1'b1;
          w_settle_nxt         = SCW'(SETTLE_CYCLES);
          w_state_nxt          = SETTLE;
        end
      end
      SETTLE: begin
        w_settle_nxt = r_settle - SCW'(1);
        if (r_settle == SCW'(1)) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (!w_match) begin
          w_error_vector_nxt   = r_stim;
          w_error_response_nxt = {dut_carry_out, dut_sum};
          w_fail_nxt           = 1'b1;
          w_done_nxt           = 1'b1;
          w_busy_nxt           = 1'b0;
          w_state_nxt          = DONE;
        end else if (w_last) begin
          w_vector_count_nxt   = VCW'(N_VECTORS);
          w_pass_nxt           = 1'b1;
          w_done_nxt           = 1'b1;
          w_busy_nxt           = 1'b0;
          w_state_nxt          = DONE;
        end else begin
          w_vector_count_nxt   = r_vector_count + VCW'(1);
          w_stim_nxt           = {r_lfsr[0], r_lfsr[1], r_lfsr[2]};
          w_lfsr_nxt           = lfsr_next(r_lfsr);
          w_settle_nxt         = SCW'(SETTLE_CYCLES);
          w_state_nxt          = SETTLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr           <= LFSR_SEED;
      r_stim           <= '0;
      r_settle         <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail           <= 1'b0;
      r_vector_count   <= '0;
      r_error_vector   <= '0;
      r_error_response <= '0;
    end else begin
      r_lfsr           <= w_lfsr_nxt;
      r_stim           <= w_stim_nxt;
      r_settle         <= w_settle_nxt;
      r_busy           <= w_busy_nxt;
      r_done           <= w_done_nxt;
      r_pass           <= w_pass_nxt;
      r_fail           <= w_fail_nxt;
      r_vector_count   <= w_vector_count_nxt;
      r_error_vector   <= w_error_vector_nxt;
      r_error_response <= w_error_response_nxt;
    end
  end

  assign {dut_a, dut_b, dut_carry_in} = r_stim;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail           = r_fail;
  assign vector_count   = r_vector_count;
  assign error_vector   = r_error_vector;
  assign error_response = r_error_response;

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: a correct, a carry-stuck and a
// two-register-delayed adder model, with a vector reference built from the
// LFSR recurrence in plain integer arithmetic.
module tb_adder_bist;

  localparam int NV = 100;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  int   mode0;   // 0 correct adder, 1 carry_out stuck at 0, 2 two-cycle delay
  int   sel;     // 0 -> dut0 (SETTLE_CYCLES=1), 1 -> dut1 (SETTLE_CYCLES=3)
  int   checks = 0;
  int   errors = 0;

  logic       a0, b0, c0, sum0, co0, busy0, done0, pass0, fail0;
  logic [6:0] vc0;
  logic [2:0] ev0;
  logic [1:0] er0;
  logic       a1, b1, c1, sum1, co1, busy1, done1, pass1, fail1;
  logic [6:0] vc1;
  logic [2:0] ev1;
  logic [1:0] er1;
  logic [1:0] d0_1, d0_2, d1_1, d1_2;
  logic [2:0] vec [NV];

  always #5 clk = ~clk;

  adder_bist #(.N_VECTORS(100), .SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_carry_in(c0),
    .dut_sum(sum0), .dut_carry_out(co0),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
    .vector_count(vc0), .error_vector(ev0), .error_response(er0)
  );

  adder_bist #(.N_VECTORS(100), .SETTLE_CYCLES(3), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_carry_in(c1),
    .dut_sum(sum1), .dut_carry_out(co1),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .vector_count(vc1), .error_vector(ev1), .error_response(er1)
  );

  // Adder models under test
  wire [1:0] s0 = 2'(a0) + 2'(b0) + 2'(c0);
  wire [1:0] s1 = 2'(a1) + 2'(b1) + 2'(c1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_1 <= 2'b00; d0_2 <= 2'b00; d1_1 <= 2'b00; d1_2 <= 2'b00;
    end else begin
      d0_1 <= s0; d0_2 <= d0_1; d1_1 <= s1; d1_2 <= d1_1;
    end
  end

  assign sum0 = (mode0 == 2) ? d0_2[0] : s0[0];
  assign co0  = (mode0 == 0) ? s0[1] : (mode0 == 1) ? 1'b0 : d0_2[1];
  assign sum1 = d1_2[0];
  assign co1  = d1_2[1];

  // View of whichever controller is selected
  wire       m_a    = (sel != 0) ? a1 : a0;
  wire       m_b    = (sel != 0) ? b1 : b0;
  wire       m_c    = (sel != 0) ? c1 : c0;
  wire       m_busy = (sel != 0) ? busy1 : busy0;
  wire       m_done = (sel != 0) ? done1 : done0;
  wire       m_pass = (sel != 0) ? pass1 : pass0;
  wire       m_fail = (sel != 0) ? fail1 : fail0;
  wire [6:0] m_vc   = (sel != 0) ? vc1 : vc0;
  wire [2:0] m_ev   = (sel != 0) ? ev1 : ev0;
  wire [1:0] m_er   = (sel != 0) ? er1 : er0;

  function automatic logic [1:0] add3(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  // Reference vector list: {a,b,cin} taken from the low three LFSR bits
  task automatic build_model();
    int l;
    l = 'hACE1;
    for (int i = 0; i < NV; i++) begin
      vec[i] = {1'(l % 2), 1'((l / 2) % 2), 1'((l / 4) % 2)};
      l = (l / 2) ^ (((l % 2) == 1) ? 'hB400 : 0);
    end
  endtask

  // Start a run on the selected controller, hold start for 'hold' edges,
  // follow it to done and check the stimulus stream on every cycle.
  task automatic run_once(input int hold, input int budget, output int cyc,
                          output int stim_err, output logic [2:0] first,
                          output logic timed_out);
    int sp;
    int k;
    logic fin;
    sp = (sel != 0) ? 4 : 2;
    stim_err = 0; timed_out = 1'b0; first = 3'b000; fin = 1'b0; k = 0;
    @(negedge clk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    while (!fin) begin
      @(posedge clk); #1;
      if (k == hold - 1) begin start0 = 1'b0; start1 = 1'b0; end
      if (k == 0) first = {m_a, m_b, m_c};
      if (m_done === 1'b1) begin
        fin = 1'b1;
      end else begin
        if ((k / sp) < NV) begin
          if ({m_a, m_b, m_c} !== vec[k / sp] || m_busy !== 1'b1) stim_err++;
        end else begin
          stim_err++;
        end
        k++;
        if (k > budget) begin timed_out = 1'b1; fin = 1'b1; end
      end
    end
    start0 = 1'b0; start1 = 1'b0;
    cyc = k;
  endtask

  task automatic check_outcome(input string name, input int cyc, input int exp_cyc,
                               input int stim_err, input logic timed_out,
                               input logic exp_pass, input int exp_vc);
    checks++;
    if (timed_out) begin
      errors++; $display("FAIL %s_timeout: done not seen after %0d cycles", name, cyc);
    end
    checks++;
    if (cyc !== exp_cyc) begin
      errors++; $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (stim_err !== 0) begin
      errors++; $display("FAIL %s_stimulus: %0d bad stimulus/busy cycles, expected 0", name, stim_err);
    end
    checks++;
    if ({m_done, m_pass, m_fail, m_busy} !== {1'b1, exp_pass, !exp_pass, 1'b0}) begin
      errors++;
      $display("FAIL %s_flags: done/pass/fail/busy=%b, expected %b", name,
               {m_done, m_pass, m_fail, m_busy}, {1'b1, exp_pass, !exp_pass, 1'b0});
    end
    checks++;
    if (m_vc !== 7'(exp_vc)) begin
      errors++; $display("FAIL %s_count: got %0d, expected %0d", name, m_vc, exp_vc);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({a0, b0, c0, busy0, done0, pass0, fail0, vc0, ev0, er0,
         a1, b1, c1, busy1, done1, pass1, fail1, vc1, ev1, er1} !== '0) begin
      errors++;
      $display("FAIL %s_zero: dut0 outs=%b dut1 outs=%b, expected all 0", name,
               {a0, b0, c0, busy0, done0, pass0, fail0, vc0, ev0, er0},
               {a1, b1, c1, busy1, done1, pass1, fail1, vc1, ev1, er1});
    end
  endtask

  task automatic test_reset();
    int bad;
    @(posedge clk); #($urandom_range(2, 4));
    rst = 1'b1; #1;
    check_all_zero("reset");
    checks++;
    if (dut0.r_lfsr !== 16'hACE1) begin
      errors++; $display("FAIL reset_lfsr: got %h, expected ace1", dut0.r_lfsr);
    end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if ({a0, b0, c0, busy0, done0} !== 5'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_idle: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_pass_run();
    int cyc, se; logic [2:0] first; logic to;
    sel = 0; mode0 = 0;
    run_once(1, 400, cyc, se, first, to);
    checks++;
    if (first !== 3'b100) begin
      errors++; $display("FAIL pass_first_vector: got %b, expected 100", first);
    end
    check_outcome("pass_run", cyc, 200, se, to, 1'b1, 100);
  endtask

  task automatic test_carry_stuck();
    int cyc, se, idx; logic [2:0] first; logic to; logic [1:0] sm;
    sel = 0; mode0 = 1; idx = -1;
    for (int i = NV - 1; i >= 0; i--) if (add3(vec[i]) >= 2'd2) idx = i;
    run_once(1, 400, cyc, se, first, to);
    check_outcome("stuck", cyc, (idx + 1) * 2, se, to, 1'b0, idx);
    checks++;
    if (ev0 !== vec[idx]) begin
      errors++; $display("FAIL stuck_err_vector: got %b, expected %b", ev0, vec[idx]);
    end
    sm = add3(vec[idx]);
    checks++;
    if (er0 !== {1'b0, sm[0]}) begin
      errors++; $display("FAIL stuck_err_response: got %b, expected %b", er0, {1'b0, sm[0]});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, se, gap, bad; logic [2:0] first; logic to;
    sel = 0; mode0 = 0;
    run_once($urandom_range(2, 60), 400, cyc, se, first, to);
    check_outcome("held_start", cyc, 200, se, to, 1'b1, 100);
    gap = $urandom_range(1, 10); bad = 0;
    repeat (gap) begin
      @(posedge clk); #1;
      if ({done0, pass0, vc0, a0, b0, c0} !== {1'b1, 1'b1, 7'd100, vec[NV - 1]}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL done_hold: %0d cycles lost DONE outputs, expected 0", bad);
    end
    run_once(1, 400, cyc, se, first, to);
    check_outcome("rerun", cyc, 200, se, to, 1'b1, 100);
  endtask

  task automatic test_abort();
    int cyc, se; logic [2:0] first; logic to;
    sel = 0; mode0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (74) @(posedge clk);
    #1;
    checks++;
    if ({busy0, vc0} !== {1'b1, 7'd37}) begin
      errors++; $display("FAIL abort_pre: busy/count=%b/%0d, expected 1/37", busy0, vc0);
    end
    #($urandom_range(1, 3)); rst = 1'b1; #1;
    check_all_zero("abort");
    @(negedge clk); rst = 1'b0;
    run_once(1, 400, cyc, se, first, to);
    check_outcome("after_abort", cyc, 200, se, to, 1'b1, 100);
  endtask

  task automatic test_delayed();
    int cyc, se, j; logic [2:0] first, prev; logic to;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    sel = 0; mode0 = 2; j = -1;
    for (int i = NV - 1; i >= 0; i--) begin
      prev = (i == 0) ? 3'b000 : vec[i - 1];
      if (add3(vec[i]) != add3(prev)) j = i;
    end
    prev = (j == 0) ? 3'b000 : vec[j - 1];
    run_once(1, 400, cyc, se, first, to);
    check_outcome("delay_s1", cyc, (j + 1) * 2, se, to, 1'b0, j);
    checks++;
    if ({ev0, er0} !== {vec[j], add3(prev)}) begin
      errors++;
      $display("FAIL delay_s1_capture: vec/resp=%b/%b, expected %b/%b", ev0, er0, vec[j], add3(prev));
    end
    sel = 1;
    run_once(1, 800, cyc, se, first, to);
    check_outcome("delay_s3", cyc, 400, se, to, 1'b1, 100);
    sel = 0;
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0; sel = 0;
    build_model();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_pass_run();
    test_carry_stuck();
    test_back_to_back();
    test_abort();
    test_delayed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
Hardware built-in self-test controller for the combinational full_adder, intended for on-board checking.
- Generates pseudo-random a/b/carry_in vectors from an LFSR and drives them into the adder under test.
- After a settle interval, compares {carry_out, sum} against a + b + carry_in.
- Counts passing vectors and reports pass/fail plus the first failing vector and response on board LEDs.

Parameters:
N_VECTORS, 100, number of vectors per run; must be >= 1.
SETTLE_CYCLES, 1, cycles between applying a vector and sampling the response; must be >= 1.
LFSR_SEED, 16'hACE1, LFSR reload value; must be nonzero (elaboration-time check).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  pulse or level; starts a run when the block is not busy
dut_a  out  1  stimulus a to the adder under test (registered)
dut_b  out  1  stimulus b (registered)
dut_carry_in  out  1  stimulus carry_in (registered)
dut_sum  in  1  adder sum response
dut_carry_out  in  1  adder carry_out response
busy  out  1  run in progress
done  out  1  run finished; held until next start or reset
pass  out  1  all N_VECTORS matched; valid while done=1
fail  out  1  mismatch detected; valid while done=1
vector_count  out  $clog2(N_VECTORS+1)  number of vectors checked and matched so far
error_vector  out  3  {a,b,carry_in} of the first failing vector
error_response  out  2  {carry_out,sum} captured at the failure

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; lfsr=LFSR_SEED.
  - All outputs 0: dut_*, busy, done, pass, fail, vector_count, error_vector, error_response.
- LFSR:
  - 16-bit Galois, right-shifting; mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Vector source: a=lfsr[0], b=lfsr[1], carry_in=lfsr[2].
  - Advances exactly once per vector loaded.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE, start=1:
  - Load dut_a/dut_b/dut_carry_in from LFSR_SEED[2:0] and set lfsr <= next(LFSR_SEED), so every run is reproducible.
  - Clear vector_count, done, pass, fail, error_vector and error_response.
  - Set busy=1, load settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - Go to CHECK on the cycle the counter reaches 1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): compare {dut_carry_out,dut_sum} with the 2-bit zero-extended sum dut_a+dut_b+dut_carry_in. Compare with X counted as mismatch, i.e. equivalent of !==; synthesis uses plain compare.
  - Mismatch:
    - Capture error_vector={dut_a,dut_b,dut_carry_in} and error_response={dut_carry_out,dut_sum}.
    - Set fail=1, done=1, busy=0; go to DONE.
    - vector_count is not incremented; it equals the 0-based index of the failing vector.
  - Match, and vector_count+1 == N_VECTORS:
    - vector_count <= N_VECTORS; pass=1, done=1, busy=0; go to DONE.
  - Match otherwise:
    - vector_count++; load the next vector from lfsr[2:0] and advance lfsr.
    - Reload the settle counter; go to SETTLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - For a fault-free run, done rises N_VECTORS*(SETTLE_CYCLES+1) cycles after the start-accept edge.
  - pass and fail are never both 1.
- start while busy is ignored; no restart and no effect on counters.
- DONE holds done, pass/fail, vector_count, error_* and the last stimulus until start or rst.
- rst mid-run aborts immediately to the reset values; the next start behaves exactly as the first run after power-up.

Test Plan:
1. Assert rst asynchronously between clock edges -> all outputs 0 immediately; lfsr=16'hACE1. After release, no activity until start.
2. Correct full_adder, defaults, 1-cycle start pulse -> busy=1 for 200 cycles. First vector a=1,b=0,carry_in=0. Then done=1, pass=1, fail=0, vector_count=100.
3. Fault DUT with carry_out stuck at 0 -> fail=1 in the CHECK of the first vector with a+b+carry_in>=2. error_response[1]=0; error_vector matches the LFSR-predicted vector; vector_count equals its index.
4. start held high during a run -> no restart. Second start from DONE -> stimulus sequence bit-identical to run 1, same completion cycle.
5. rst pulsed at vector 37 -> outputs return to 0. A subsequent run completes with pass=1, vector_count=100.
6. DUT wrapped with a 2-cycle registered delay:
   - SETTLE_CYCLES=3 -> pass=1 after 400 cycles.
   - SETTLE_CYCLES=1 -> fail=1 on the first vector whose expected value differs from the delayed response.
